// File: rtl/containment_panel_if.sv
// Signal bundle between the scp_079 containment core and the containment panel:
// alarm/cheat/acknowledge inputs toward the panel, status lights and counters back.
interface containment_panel_if;
  logic       a1;
  logic       a2;
  logic       a3;
  logic       cheat_out;
  logic       operator_ack;
  logic       green;
  logic       yellow;
  logic       red;
  logic       lockdown;
  logic [1:0] panel_state;
  logic [3:0] breach_count;

  // master drives the alarms (core / operator side), slave is the panel
  modport master (
    output a1, a2, a3, cheat_out, operator_ack,
    input  green, yellow, red, lockdown, panel_state, breach_count
  );

  modport slave (
    input  a1, a2, a3, cheat_out, operator_ack,
    output green, yellow, red, lockdown, panel_state, breach_count
  );
endinterface

// File: rtl/containment_panel.sv
// Containment status panel: SECURE/ALERT/BREACH/LOCKDOWN escalation with registered lights.
// Optional feature macro: PANEL_BLINK_EN (red blinks every BLINK_HALF cycles in LOCKDOWN).
module containment_panel #(
  parameter int CLEAR_CYCLES   = 8,
  parameter int ALERT_LIMIT    = 30,
  parameter int HOLD_CYCLES    = 5,
  parameter int LOCK_THRESHOLD = 3,
  parameter int BLINK_HALF     = 500
) (
  input logic                 clock,
  input logic                 reset,
  containment_panel_if.slave  bus
);

  if (CLEAR_CYCLES < 1 || CLEAR_CYCLES > 1023 || ALERT_LIMIT < 1 || ALERT_LIMIT > 1023 ||
      HOLD_CYCLES < 1 || HOLD_CYCLES > 1023 || LOCK_THRESHOLD < 1 || LOCK_THRESHOLD > 15 ||
      BLINK_HALF < 1 || BLINK_HALF > 1023) begin : g_param_check
    $error("containment_panel: parameter out of range");
  end

  localparam logic [9:0] CLEAR_LIM = 10'(CLEAR_CYCLES);
  localparam logic [9:0] ALERT_LIM = 10'(ALERT_LIMIT);
  localparam logic [9:0] HOLD_LIM  = 10'(HOLD_CYCLES);
  localparam logic [3:0] LOCK_LIM  = 4'(LOCK_THRESHOLD);

  typedef enum logic [1:0] {
    SECURE   = 2'd0,
    ALERT    = 2'd1,
    BREACH   = 2'd2,
    LOCKDOWN = 2'd3
  } state_t;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3ff) ? v : v + 10'd1;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction

  state_t     st, st_nx;
  logic [9:0] sus_cnt, sus_nx;
  logic [9:0] clr_cnt, clr_nx;
  logic [9:0] hold_cnt, hold_nx;
  logic [3:0] bcnt, bcnt_nx;
  logic       green_p1, yellow_p1, red_p1, lockdown_p1;
  logic       red_nx;
  logic       any_alarm, multi_alarm;

  assign any_alarm   = bus.a1 | bus.a2 | bus.a3;
  assign multi_alarm = (bus.a1 & bus.a2) | (bus.a1 & bus.a3) | (bus.a2 & bus.a3);

  // Next-state decision; limits are tested on the counter values already reached
  always_comb begin
    st_nx   = st;
    sus_nx  = sus_cnt;
    clr_nx  = clr_cnt;
    hold_nx = hold_cnt;
    bcnt_nx = bcnt;
    unique case (st)
      SECURE: begin
        if (bus.cheat_out)  st_nx = BREACH;
        else if (any_alarm) st_nx = ALERT;
      end
      ALERT: begin
        if (bus.cheat_out || multi_alarm)           st_nx = BREACH;
        else if (sus_cnt >= ALERT_LIM)              st_nx = BREACH;
        else if (!any_alarm && clr_cnt >= CLEAR_LIM) st_nx = SECURE;
        else if (any_alarm) begin
          sus_nx = sat_inc10(sus_cnt);
          clr_nx = '0;
        end else begin
          clr_nx = sat_inc10(clr_cnt);
          sus_nx = '0;
        end
      end
      BREACH: begin
        if (bcnt >= LOCK_LIM) st_nx = LOCKDOWN;
        else if (hold_cnt >= HOLD_LIM && !any_alarm && !bus.cheat_out) st_nx = ALERT;
        else if (hold_cnt < HOLD_LIM) hold_nx = sat_inc10(hold_cnt);
      end
      LOCKDOWN: begin
        if (bus.operator_ack) begin
          st_nx   = SECURE;
          bcnt_nx = '0;
        end
      end
      default: st_nx = SECURE;
    endcase
    // every state entry restarts the counters; a BREACH entry also counts itself
    if (st_nx != st) begin
      sus_nx  = '0;
      clr_nx  = '0;
      hold_nx = '0;
      if (st_nx == BREACH) bcnt_nx = sat_inc4(bcnt);
    end
  end

`ifdef PANEL_BLINK_EN
  localparam logic [9:0] BLINK_LAST = 10'(BLINK_HALF - 1);
  logic [9:0] blink_cnt, blink_nx;

  always_comb begin
    blink_nx = '0;
    red_nx   = (st_nx == BREACH);
    if (st_nx == LOCKDOWN) begin
      if (st != LOCKDOWN) begin
        red_nx = 1'b1;
      end else if (blink_cnt >= BLINK_LAST) begin
        red_nx = ~red_p1;
      end else begin
        red_nx   = red_p1;
        blink_nx = blink_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) blink_cnt <= '0;
    else       blink_cnt <= blink_nx;
  end
`else
  assign red_nx = (st_nx == BREACH) || (st_nx == LOCKDOWN);
`endif

  // Register stage: state, counters and the lights decoded from the next state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st          <= SECURE;
      sus_cnt     <= '0;
      clr_cnt     <= '0;
      hold_cnt    <= '0;
      bcnt        <= '0;
      green_p1    <= 1'b1;
      yellow_p1   <= 1'b0;
      red_p1      <= 1'b0;
      lockdown_p1 <= 1'b0;
    end else begin
      st          <= st_nx;
      sus_cnt     <= sus_nx;
      clr_cnt     <= clr_nx;
      hold_cnt    <= hold_nx;
      bcnt        <= bcnt_nx;
      green_p1    <= (st_nx == SECURE);
      yellow_p1   <= (st_nx == ALERT);
      red_p1      <= red_nx;
      lockdown_p1 <= (st_nx == LOCKDOWN);
    end
  end

  assign bus.green        = green_p1;
  assign bus.yellow       = yellow_p1;
  assign bus.red          = red_p1;
  assign bus.lockdown     = lockdown_p1;
  assign bus.panel_state  = st;
  assign bus.breach_count = bcnt;

endmodule

// File: doc/containment_panel.md
# containment_panel

Facility status panel that closes the loop around the `scp_079` containment core. It watches the core's alarm outputs (`a1`, `a2`, `a3`) and its `cheat_out` flag, and escalates through secure, alert, breach and lockdown states. It drives the one-hot `green`/`yellow`/`red` light lines that feed back into `scp_079`, and counts breaches until an operator acknowledges a lockdown.

## Interface
Parameters:
- `CLEAR_CYCLES`, 8: consecutive alarm-free cycles that return ALERT to SECURE.
- `ALERT_LIMIT`, 30: consecutive cycles with any alarm in ALERT before escalating to BREACH.
- `HOLD_CYCLES`, 5: minimum BREACH dwell before de-escalation is allowed.
- `LOCK_THRESHOLD`, 3: breach count that forces LOCKDOWN.
- `BLINK_HALF`, 500: blink half-period in cycles (only with `PANEL_BLINK_EN`).
- All cycle parameters are in the range 1..1023; `LOCK_THRESHOLD` is in the range 1..15.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `a1`, `a2`, `a3`  in  1 each  alarm flags from the core.
- `cheat_out`  in  1  core integrity-violation flag.
- `operator_ack`  in  1  single-cycle operator acknowledge.
- `green`, `yellow`, `red`  out  1 each  status lights, registered, one-hot except while blinking.
- `lockdown`  out  1  high in LOCKDOWN.
- `panel_state`  out  2  encoding: 0 SECURE, 1 ALERT, 2 BREACH, 3 LOCKDOWN.
- `breach_count`  out  4  BREACH entries since the last clear, saturating at 15.

## Operation
- Definitions: `any_alarm = a1|a2|a3`; `multi_alarm` means at least two of `a1`, `a2`, `a3` are high.
- SECURE drives `green`.
  - `cheat_out` moves to BREACH.
  - Otherwise `any_alarm` moves to ALERT.
- ALERT drives `yellow`.
  - `cheat_out` or `multi_alarm` moves to BREACH.
  - Otherwise the sustain counter increments on each cycle with `any_alarm` and resets to 0 on each alarm-free cycle. Reaching `ALERT_LIMIT` moves to BREACH.
  - The clear counter increments on each alarm-free cycle and resets on any alarm. Reaching `CLEAR_CYCLES` moves to SECURE.
- BREACH drives `red`.
  - On entry: `breach_count` increments (saturating) and the hold counter starts at 0.
  - If the new count is at least `LOCK_THRESHOLD`, move to LOCKDOWN on the next cycle.
  - Otherwise, once the hold counter reaches `HOLD_CYCLES`, a cycle with neither `any_alarm` nor `cheat_out` moves to ALERT, where counters restart.
- LOCKDOWN drives `red` and `lockdown`.
  - All alarm and cheat inputs are ignored.
  - `operator_ack` moves to SECURE and clears `breach_count` to 0.
  - `operator_ack` is ignored in all other states.
- Event precedence within one cycle, highest first: reset, `cheat_out`, `multi_alarm`, sustain limit, clear limit.
- All counters are 10-bit and are zeroed on every state entry.

## Timing
- Outputs are registered. Inputs sampled at edge N are reflected in the lights and `panel_state` after edge N, i.e. one cycle of latency.
- Reset is asynchronous. It immediately forces:
  - SECURE, `green`=1, `yellow`=0, `red`=0
  - `lockdown`=0, `breach_count`=0, `panel_state`=0
  - all counters to 0
- Reset mid-operation, including in LOCKDOWN, abandons all counts.
- SECURE→ALERT→SECURE with a single one-cycle alarm: ALERT lasts exactly `CLEAR_CYCLES`+1 cycles.
- BREACH→LOCKDOWN: BREACH is held exactly 1 cycle when the threshold is hit.
- `breach_count` updates in the same cycle that `panel_state` becomes 2.

## Configuration
- `PANEL_BLINK_EN` defined: in LOCKDOWN, `red` toggles every `BLINK_HALF` cycles.
  - `red` is 1 in the first cycle of LOCKDOWN.
  - The blink counter resets on LOCKDOWN entry.
  - `lockdown` stays steady high.
- `PANEL_BLINK_EN` undefined: `red` is steady 1 in LOCKDOWN and the blink counter is not synthesized.

## Test plan
- Reset, then idle 10 cycles with all inputs 0 -> `green`=1, `panel_state`=0, `breach_count`=0 throughout.
- `a1` pulsed 1 cycle from SECURE -> ALERT (`yellow`=1) on the next cycle, back to SECURE 9 cycles later with default parameters.
- `a2` held high for 30 cycles in ALERT -> BREACH, `red`=1, `breach_count`=1. `a2` dropped -> ALERT after the 5-cycle hold.
- `a1`=`a3`=1 in the same cycle from ALERT, and separately `cheat_out`=1 from SECURE -> immediate BREACH in both cases, with `breach_count` incrementing.
- Three `cheat_out` pulses spaced 10 cycles apart -> third BREACH lasts 1 cycle, then LOCKDOWN with `lockdown`=1. Alarms are then ignored. `operator_ack` -> SECURE with `breach_count`=0.
- `reset` asserted mid-LOCKDOWN, and in a `PANEL_BLINK_EN` build with `BLINK_HALF`=4 -> reset gives `green`=1 asynchronously. In the blink build, `red` toggles every 4 cycles in LOCKDOWN.
